id_ex_stage: RTL and testbench

ID/EX pipeline stage that feeds the 32-bit ALU in the pipelined MIPS datapath. It registers decoded operands and control from ID, then presents ALU inputs (operation, A, B, shamt) to EX. It resolves data hazards by forwarding from EX/MEM and MEM/WB, and it detects load-use hazards, inserting bubbles and stalling IF/ID.

---
 rtl/id_ex_stage_pkg.sv | 36 +++
 rtl/id_ex_stage_hazard_forward_unit.sv | 74 +++++++
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: types and constants shared by the ID/EX stage and its
// hazard/forwarding unit.
//   alu_op_e    - ALUOperation codes presented to the 32-bit ALU
//   fwd_sel_e   - operand source selected by the forwarding logic
//   ctrl_t      - control bits carried through the ID/EX register
//   CTRL_BUBBLE - control value of an inserted bubble (everything off)
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_NOR = 4'b0010,
    ALU_ADD = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_LUI = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_forward_unit.sv
// hazard_forward_unit: operand forward selects for the instruction in EX and
// the raw hazard request for the instruction waiting in ID.
// Optional feature macro: ID_EX_FORWARDING_EN.
//   defined   - selects pick EX/MEM over MEM/WB over register data; only a
//               load-use dependence raises hazard.
//   undefined - selects are always FWD_REG; any nonzero ID source matching a
//               pending write in EX or EX/MEM raises hazard.
// Ports:
//   ex_rs/ex_rt/ex_write_reg/ex_reg_write/ex_mem_read - registered EX fields
//   id_rs/id_rt                                       - ID source indices
//   exmem_*/memwb_*                                   - downstream writers
//   fwd_a/fwd_b                                       - rs/rt operand source
//   hazard                                            - ID must be held
module hazard_forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] exmem_write_reg,
  input  logic             exmem_reg_write,
  input  logic [REG_W-1:0] memwb_write_reg,
  input  logic             memwb_reg_write,
  output fwd_sel_e         fwd_a,
  output fwd_sel_e         fwd_b,
  output logic             hazard
);

`ifdef ID_EX_FORWARDING_EN
  logic exmem_live, memwb_live;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign exmem_live = exmem_reg_write && (exmem_write_reg != '0);
  assign memwb_live = memwb_reg_write && (memwb_write_reg != '0);

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (exmem_live && (exmem_write_reg == ex_rs)) fwd_a = FWD_EXMEM;
    else if (memwb_live && (memwb_write_reg == ex_rs)) fwd_a = FWD_MEMWB;
    if (exmem_live && (exmem_write_reg == ex_rt)) fwd_b = FWD_EXMEM;
    else if (memwb_live && (memwb_write_reg == ex_rt)) fwd_b = FWD_MEMWB;
    // A load's data only exists after MEM, so its consumer in ID must wait.
    hazard = ex_mem_read && (ex_write_reg != '0) &&
             ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));
  end

  logic unused_inputs;
  assign unused_inputs = ex_reg_write;
`else
  always_comb begin
    fwd_a  = FWD_REG;
    fwd_b  = FWD_REG;
    // Without bypassing, ID waits until the producer reaches WB, where the
    // register file writes before it reads.
    hazard = ((id_rs != '0) &&
              ((ex_reg_write && (ex_write_reg == id_rs)) ||
               (exmem_reg_write && (exmem_write_reg == id_rs)))) ||
             ((id_rt != '0) &&
              ((ex_reg_write && (ex_write_reg == id_rt)) ||
               (exmem_reg_write && (exmem_write_reg == id_rt))));
  end

  logic unused_inputs;
  assign unused_inputs = ^{ex_rs, ex_rt, ex_mem_read, memwb_write_reg, memwb_reg_write};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the 32-bit ALU, with operand
// forwarding and load-use / RAW stall generation.
// Optional feature macro: ID_EX_FORWARDING_EN (see hazard_forward_unit).
// Ports:
//   clk, reset (sync, active-high), flush (load bubble), hold (freeze)
//   id_*      - decoded operands, indices and control from ID
//   exmem_*   - destination/write-enable/result of the instruction in MEM
//   memwb_*   - destination/write-enable/result of the instruction in WB
//   ex_*      - ALU inputs, store data and control presented to EX
//   stall_if_id - freezes PC and IF/ID while ID waits for a producer
// Register update priority: reset > flush > hold > hazard bubble > load.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_write_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic [REG_W-1:0]  exmem_write_reg,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_W-1:0]  memwb_write_reg,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [3:0]        ex_alu_operation,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_valid,
  output logic              stall_if_id
);

  logic [3:0]        alu_op_d, alu_op_q;
  logic [DATA_W-1:0] rs_data_d, rs_data_q;
  logic [DATA_W-1:0] rt_data_d, rt_data_q;
  logic [DATA_W-1:0] imm_d, imm_q;
  logic [4:0]        shamt_d, shamt_q;
  logic              alu_src_d, alu_src_q;
  logic [REG_W-1:0]  rs_d, rs_q, rt_d, rt_q, write_reg_d, write_reg_q;
  ctrl_t             ctrl_d, ctrl_q;

  fwd_sel_e          fwd_a, fwd_b;
  logic              hazard;
  logic              load_bubble, load_new;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  hazard_forward_unit #(.REG_W(REG_W)) u_hazard_forward_unit (
    .ex_rs           (rs_q),
    .ex_rt           (rt_q),
    .ex_write_reg    (write_reg_q),
    .ex_reg_write    (ctrl_q.reg_write),
    .ex_mem_read     (ctrl_q.mem_read),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .exmem_write_reg (exmem_write_reg),
    .exmem_reg_write (exmem_reg_write),
    .memwb_write_reg (memwb_write_reg),
    .memwb_reg_write (memwb_reg_write),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .hazard          (hazard)
  );

  // hold outranks a hazard bubble, so a frozen stage keeps its instruction
  // and stall_if_id keeps tracking the frozen contents.
  assign load_bubble = flush || (!hold && hazard);
  assign load_new    = !flush && !hold && !hazard;

  always_comb begin
    alu_op_d    = alu_op_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    alu_src_d   = alu_src_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    write_reg_d = write_reg_q;
    ctrl_d      = ctrl_q;
    if (load_bubble) begin
      alu_op_d    = ALU_AND;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      shamt_d     = '0;
      alu_src_d   = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      write_reg_d = '0;
      ctrl_d      = CTRL_BUBBLE;
    end else if (load_new) begin
      alu_op_d    = id_alu_op;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm_ext;
      shamt_d     = id_shamt;
      alu_src_d   = id_alu_src;
      rs_d        = id_rs;
      rt_d        = id_rt;
      write_reg_d = id_write_reg;
      ctrl_d      = '{reg_write: id_reg_write, mem_read: id_mem_read,
                      mem_write: id_mem_write, mem_to_reg: id_mem_to_reg,
                      valid: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op_q    <= ALU_AND;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      alu_src_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      write_reg_q <= '0;
      ctrl_q      <= CTRL_BUBBLE;
    end else begin
      alu_op_q    <= alu_op_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      alu_src_q   <= alu_src_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      write_reg_q <= write_reg_d;
      ctrl_q      <= ctrl_d;
    end
  end

  function automatic logic [DATA_W-1:0] fwd_mux(input fwd_sel_e sel,
                                                input logic [DATA_W-1:0] reg_val,
                                                input logic [DATA_W-1:0] exmem_val,
                                                input logic [DATA_W-1:0] memwb_val);
    case (sel)
      FWD_EXMEM: return exmem_val;
      FWD_MEMWB: return memwb_val;
      default:   return reg_val;
    endcase
  endfunction

  always_comb begin
    fwd_rs = fwd_mux(fwd_a, rs_data_q, exmem_result, memwb_result);
    fwd_rt = fwd_mux(fwd_b, rt_data_q, exmem_result, memwb_result);
  end

  assign ex_alu_operation = alu_op_q;
  assign ex_a             = fwd_rs;
  assign ex_b             = alu_src_q ? imm_q : fwd_rt;
  assign ex_shamt         = shamt_q;
  assign ex_store_data    = fwd_rt;
  assign ex_write_reg     = write_reg_q;
  assign ex_reg_write     = ctrl_q.reg_write;
  assign ex_mem_read      = ctrl_q.mem_read;
  assign ex_mem_write     = ctrl_q.mem_write;
  assign ex_mem_to_reg    = ctrl_q.mem_to_reg;
  assign ex_valid         = ctrl_q.valid;
  // A taken branch discards the waiting ID instruction, so it need not stall.
  assign stall_if_id      = hazard && !flush;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: bench for id_ex_stage. The bench keeps its own picture of
// the instruction sitting in EX (and, for directed sequences, of the MEM/WB
// instructions and the register file), derives every expected output from
// the stage rules, and compares each cycle.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, flush, hold;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]        id_shamt;
  logic [3:0]        id_alu_op;
  logic              id_alu_src;
  logic [REG_W-1:0]  id_rs, id_rt, id_write_reg;
  logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [REG_W-1:0]  exmem_write_reg, memwb_write_reg;
  logic              exmem_reg_write, memwb_reg_write;
  logic [DATA_W-1:0] exmem_result, memwb_result;
  logic [3:0]        ex_alu_operation;
  logic [DATA_W-1:0] ex_a, ex_b, ex_store_data;
  logic [4:0]        ex_shamt;
  logic [REG_W-1:0]  ex_write_reg;
  logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic              ex_valid, stall_if_id;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_rs(id_rs), .id_rt(id_rt), .id_write_reg(id_write_reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_write_reg(exmem_write_reg), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .memwb_write_reg(memwb_write_reg),
    .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .ex_alu_operation(ex_alu_operation), .ex_a(ex_a), .ex_b(ex_b),
    .ex_shamt(ex_shamt), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid),
    .stall_if_id(stall_if_id)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic        valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt, rs, rt, wr;
  } instr_t;

  instr_t      ex_m, mem_m, wb_m, nop_i, add76;
  logic [31:0] mem_res, wb_res, ex_res;
  logic [31:0] rf [32];
  bit          pipe_mode;
  logic        exp_hazard;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t bubble_i();
    instr_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] wr, input logic src, input logic [31:0] imm,
                                input logic [4:0] sh, input logic rw, input logic ld);
    instr_t i;
    i = '{default: '0};
    i.valid = 1'b1; i.op = op; i.rs = rs; i.rt = rt; i.wr = wr; i.alu_src = src;
    i.imm = imm; i.shamt = sh; i.reg_write = rw; i.mem_read = ld; i.mem_to_reg = ld;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = '{default: '0};
    i.valid      = 1'b1;
    i.op         = 4'($urandom_range(7));
    i.rs         = 5'($urandom_range(3));
    i.rt         = 5'($urandom_range(3));
    i.wr         = 5'($urandom_range(3));
    i.alu_src    = 1'($urandom_range(1));
    i.imm        = $urandom;
    i.shamt      = 5'($urandom_range(31));
    i.rs_val     = $urandom;
    i.rt_val     = $urandom;
    i.reg_write  = 1'($urandom_range(1));
    i.mem_read   = ($urandom_range(3) == 0);
    i.mem_write  = 1'($urandom_range(1));
    i.mem_to_reg = 1'($urandom_range(1));
    return i;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return ~(a | b);
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return b << 16;
      4'd6: return b << sh;
      4'd7: return b >> sh;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] addr);
    return 32'hCAFE_0000 ^ addr;
  endfunction

  // Value EX should see for a source register: newest in-flight write wins.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] reg_val);
    if (FWD_EN && idx != 0 && exmem_reg_write && exmem_write_reg == idx) return exmem_result;
    if (FWD_EN && idx != 0 && memwb_reg_write && memwb_write_reg == idx) return memwb_result;
    return reg_val;
  endfunction

  function automatic logic pending_write(input logic [4:0] idx);
    return idx != 0 && ((ex_m.reg_write && ex_m.wr == idx) ||
                        (exmem_reg_write && exmem_write_reg == idx));
  endfunction

  // Register file read with the WB write visible in the same cycle.
  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (wb_m.reg_write && wb_m.wr == idx) return wb_res;
    return rf[idx];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_id(input instr_t i);
    id_alu_op = i.op; id_alu_src = i.alu_src; id_imm_ext = i.imm; id_shamt = i.shamt;
    id_rs = i.rs; id_rt = i.rt; id_write_reg = i.wr;
    id_reg_write = i.reg_write; id_mem_read = i.mem_read;
    id_mem_write = i.mem_write; id_mem_to_reg = i.mem_to_reg;
    if (pipe_mode) begin
      id_rs_data = rf_read(i.rs);
      id_rt_data = rf_read(i.rt);
      exmem_write_reg = mem_m.wr; exmem_reg_write = mem_m.reg_write; exmem_result = mem_res;
      memwb_write_reg = wb_m.wr;  memwb_reg_write = wb_m.reg_write;  memwb_result = wb_res;
    end else begin
      id_rs_data = i.rs_val;
      id_rt_data = i.rt_val;
    end
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle();
    logic [31:0] exp_a, exp_st, exp_b;
    #1;
    exp_a  = operand(ex_m.rs, ex_m.rs_val);
    exp_st = operand(ex_m.rt, ex_m.rt_val);
    exp_b  = ex_m.alu_src ? ex_m.imm : exp_st;
    ex_res = alu_ref(ex_m.op, exp_a, exp_b, ex_m.shamt);
    if (FWD_EN)
      exp_hazard = ex_m.mem_read && ex_m.wr != 0 && (ex_m.wr == id_rs || ex_m.wr == id_rt);
    else
      exp_hazard = pending_write(id_rs) || pending_write(id_rt);
    check_eq("alu_operation", ex_alu_operation, ex_m.op);
    check_eq("ex_a", ex_a, exp_a);
    check_eq("ex_b", ex_b, exp_b);
    check_eq("shamt", ex_shamt, ex_m.shamt);
    check_eq("store_data", ex_store_data, exp_st);
    check_eq("write_reg", ex_write_reg, ex_m.wr);
    check_eq("reg_write", ex_reg_write, ex_m.reg_write);
    check_eq("mem_read", ex_mem_read, ex_m.mem_read);
    check_eq("mem_write", ex_mem_write, ex_m.mem_write);
    check_eq("mem_to_reg", ex_mem_to_reg, ex_m.mem_to_reg);
    check_eq("valid", ex_valid, ex_m.valid);
    check_eq("stall", stall_if_id, exp_hazard && !flush);
  endtask

  // Clock edge: move the model exactly as the stage should move.
  task automatic advance();
    instr_t nxt;
    @(posedge clk);
    if (reset || flush) nxt = bubble_i();
    else if (hold) nxt = ex_m;
    else if (exp_hazard) nxt = bubble_i();
    else begin
      nxt = mk(id_alu_op, id_rs, id_rt, id_write_reg, id_alu_src, id_imm_ext, id_shamt,
               id_reg_write, id_mem_read);
      nxt.mem_write = id_mem_write; nxt.mem_to_reg = id_mem_to_reg;
      nxt.rs_val = id_rs_data; nxt.rt_val = id_rt_data;
    end
    if (pipe_mode) begin
      if (reset) begin
        mem_m = bubble_i(); wb_m = bubble_i(); mem_res = 0; wb_res = 0;
      end else begin
        if (wb_m.reg_write && wb_m.wr != 0) rf[wb_m.wr] = wb_res;
        wb_m = mem_m;
        wb_res = mem_m.mem_read ? load_val(mem_res) : mem_res;
        mem_m = ex_m;
        mem_res = ex_res;
      end
    end
    ex_m = nxt;
    @(negedge clk);
  endtask

  // Present an instruction until the stage accepts it; count DUT stall cycles.
  task automatic issue(input instr_t i, output int bubbles);
    bubbles = 0;
    for (int k = 0; k < 6; k++) begin
      apply_id(i);
      settle();
      if (stall_if_id === 1'b1) bubbles++;
      if (!exp_hazard) begin
        advance();
        return;
      end
      advance();
    end
    check_eq("issue_accept", stall_if_id, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int b;
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    pipe_mode = 1'b1;
    for (int r = 0; r < 32; r++) rf[r] = 32'(r) << 8;
    rf[0] = 0; rf[1] = 32'h5; rf[2] = 32'hB;
    ex_m = bubble_i(); mem_m = bubble_i(); wb_m = bubble_i();
    mem_res = 0; wb_res = 0; ex_res = 0; exp_hazard = 1'b0;
    nop_i = mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    add76 = mk(ALU_ADD, 6, 6, 7, 0, 0, 0, 1, 0);
    apply_id(nop_i);
    advance();

    // Reset state
    settle();
    check_eq("reset_valid", ex_valid, 32'h0);
    check_eq("reset_stall", stall_if_id, 32'h0);
    check_eq("reset_ex_a", ex_a, 32'h0);
    advance();
    reset = 1'b0;

    // ADD r3=r1+r2 then SUB r4=r3-r1
    issue(mk(ALU_ADD, 1, 2, 3, 0, 0, 0, 1, 0), b);
    issue(mk(ALU_SUB, 3, 1, 4, 0, 0, 0, 1, 0), b);
    check_eq("raw_bubbles", b, FWD_EN ? 32'd0 : 32'd2);
    apply_id(nop_i); settle();
    check_eq("raw_ex_a", ex_a, 32'h10);
    check_eq("raw_ex_b", ex_b, 32'h5);
    check_eq("raw_op", ex_alu_operation, ALU_SUB);
    advance();

    // Two writers of r5 in flight: the younger (EX/MEM) value wins
    issue(mk(ALU_LUI, 0, 0, 5, 1, 32'h5555, 0, 1, 0), b);
    issue(mk(ALU_LUI, 0, 0, 5, 1, 32'hAAAA, 0, 1, 0), b);
    issue(mk(ALU_ADD, 5, 0, 8, 0, 0, 0, 1, 0), b);
    apply_id(nop_i); settle();
    check_eq("prio_ex_a", ex_a, 32'hAAAA_0000);
    advance();

    // LW r6,0x40(r0) then ADD r7=r6+r6
    issue(mk(ALU_ADD, 0, 0, 6, 1, 32'h40, 0, 1, 1), b);
    apply_id(add76); settle();
    check_eq("lu_stall", stall_if_id, 32'h1);
    advance();
    apply_id(add76); settle();
    check_eq("lu_bubble_valid", ex_valid, 32'h0);
    check_eq("lu_second_stall", stall_if_id, FWD_EN ? 32'h0 : 32'h1);
    advance();
    if (exp_hazard) issue(add76, b);
    apply_id(nop_i); settle();
    check_eq("lu_ex_a", ex_a, load_val(32'h40));
    check_eq("lu_ex_b", ex_b, load_val(32'h40));
    advance();

    // Write to r0 must never be forwarded
    issue(mk(ALU_NOR, 0, 0, 0, 0, 0, 0, 1, 0), b);
    issue(mk(ALU_ADD, 0, 0, 9, 0, 0, 0, 1, 0), b);
    apply_id(nop_i); settle();
    check_eq("r0_exmem_seen", exmem_result, 32'hFFFF_FFFF);
    check_eq("r0_ex_a", ex_a, 32'h0);
    check_eq("r0_store", ex_store_data, 32'h0);
    advance();

    // flush with a load-use condition
    issue(mk(ALU_ADD, 0, 0, 6, 1, 32'h80, 0, 1, 1), b);
    apply_id(add76); flush = 1'b1; settle();
    check_eq("flush_stall", stall_if_id, 32'h0);
    advance();
    flush = 1'b0; apply_id(nop_i); settle();
    check_eq("flush_bubble", ex_valid, 32'h0);
    advance();

    // hold for 3 cycles with new ID inputs, then release
    for (int k = 0; k < 3; k++) issue(nop_i, b);
    issue(mk(ALU_OR, 1, 2, 0, 0, 0, 0, 0, 0), b);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_id(rand_instr()); settle();
      check_eq("hold_op", ex_alu_operation, ALU_OR);
      check_eq("hold_ex_a", ex_a, 32'h5);
      advance();
    end
    hold = 1'b0;
    issue(mk(ALU_SLL, 0, 2, 0, 0, 0, 3, 0, 0), b);
    apply_id(nop_i); settle();
    check_eq("release_op", ex_alu_operation, ALU_SLL);
    check_eq("release_shamt", ex_shamt, 32'd3);
    check_eq("release_ex_b", ex_b, 32'hB);
    advance();

    // reset in the middle of a hold
    issue(mk(ALU_OR, 1, 2, 3, 0, 0, 0, 1, 0), b);
    hold = 1'b1; apply_id(nop_i); settle(); advance();
    reset = 1'b1; settle(); advance();
    reset = 1'b0; settle();
    check_eq("rst_hold_valid", ex_valid, 32'h0);
    check_eq("rst_hold_ex_a", ex_a, 32'h0);
    check_eq("rst_hold_op", ex_alu_operation, 32'h0);
    check_eq("rst_hold_wr", ex_write_reg, 32'h0);
    advance();
    hold = 1'b0;

    // reset in the middle of a load-use stall
    issue(mk(ALU_ADD, 0, 0, 6, 1, 32'h44, 0, 1, 1), b);
    apply_id(add76); settle();
    check_eq("rst_stall_before", stall_if_id, 32'h1);
    reset = 1'b1; advance();
    reset = 1'b0; apply_id(add76); settle();
    check_eq("rst_stall_after", stall_if_id, 32'h0);
    advance();

    // Randomized traffic with independent downstream writers
    pipe_mode = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(63) == 0);
      flush = ($urandom_range(15) == 0);
      hold  = ($urandom_range(7) == 0);
      exmem_write_reg = 5'($urandom_range(3));
      exmem_reg_write = 1'($urandom_range(1));
      exmem_result    = $urandom;
      memwb_write_reg = 5'($urandom_range(3));
      memwb_reg_write = 1'($urandom_range(1));
      memwb_result    = $urandom;
      apply_id(rand_instr());
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
